// File: rtl/codec_write_buffer_pkg.sv
// Shared definitions for the audio output path: sample width, stereo pair
// layout and the write-buffer FSM state encoding.
package codec_write_buffer_pkg;

    // Sample width common to the FIR filter, this buffer and the top level.
    localparam int SAMPLE_W = 24;

    // One stereo sample pair; left occupies the upper half when flattened.
    typedef struct packed {
        logic signed [SAMPLE_W-1:0] left;
        logic signed [SAMPLE_W-1:0] right;
    } stereo_pair_t;

    // Write-buffer FSM: PRIMING waits for the fill threshold, STREAMING pops.
    typedef enum logic [0:0] {
        ST_PRIMING   = 1'b0,
        ST_STREAMING = 1'b1
    } wbuf_state_t;

    // Ceiling of the underflow event counter.
    localparam logic [15:0] UFLOW_SAT = 16'hFFFF;

    // Saturating increment used for the underflow counter.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == UFLOW_SAT) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/codec_write_buffer_if.sv
// Bus between the filter (producer), the write buffer and the CODEC (consumer).
//
// Handshake semantics:
//   Filter side: a pair transfers on a cycle where in_valid && in_ready. If
//   in_valid is high while in_ready is low the pair is lost (not held) and the
//   buffer raises its sticky overflow flag; the producer does not need to hold.
//   CODEC side: write_ready means the CODEC takes writedata_* this cycle;
//   write echoes it as the strobe, so every cycle with write high is one
//   completed transfer of writedata_left/right.
interface codec_write_buffer_if
    import codec_write_buffer_pkg::*;
#(
    parameter int WIDTH = SAMPLE_W,
    parameter int DEPTH = 8
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic             in_valid;
    logic [WIDTH-1:0] in_left;
    logic [WIDTH-1:0] in_right;
    logic             in_ready;
    logic             write_ready;
    logic             write;
    logic [WIDTH-1:0] writedata_left;
    logic [WIDTH-1:0] writedata_right;
    logic [LW-1:0]    level;
    logic [15:0]      underflow_count;
    logic             overflow;

    // Driven by the filter/CODEC side (or a testbench).
    modport master (
        output in_valid, in_left, in_right, write_ready,
        input  in_ready, write, writedata_left, writedata_right,
               level, underflow_count, overflow
    );

    // Used by the write buffer itself.
    modport slave (
        input  in_valid, in_left, in_right, write_ready,
        output in_ready, write, writedata_left, writedata_right,
               level, underflow_count, overflow
    );
endinterface

// File: rtl/codec_write_buffer_stereo_fifo_mem.sv
// DEPTH x (2*WIDTH) storage for stereo pairs: synchronous write, asynchronous
// read so the FIFO head is available in the same cycle it is popped.
module stereo_fifo_mem #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               wr_en,
    input  logic [AW-1:0]      wr_addr,
    input  logic [2*WIDTH-1:0] wr_data,
    input  logic [AW-1:0]      rd_addr,
    output logic [2*WIDTH-1:0] rd_data
);
    logic [2*WIDTH-1:0] mem [DEPTH];

    // Store the incoming pair at the write pointer.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];
endmodule

// File: rtl/codec_write_buffer.sv
// Stereo write buffer between the FIR filter and the CODEC write port.
// Queues pairs, primes to a threshold, then hands one pair per CODEC
// handshake out of a registered holding stage. Underflow repeats the last
// pair and is counted; overflow drops the incoming pair and sets a flag.
module codec_write_buffer
    import codec_write_buffer_pkg::*;
#(
    parameter int          WIDTH           = SAMPLE_W,
    parameter int          DEPTH           = 8,
    parameter int          PRIME           = 4,
    // Reset value of the underflow counter; nonzero only for bring-up runs
    // that need to reach saturation without 65k real underflows.
    parameter logic [15:0] UNDERFLOW_RESET = 16'h0000
) (
    input  logic                clk,
    input  logic                reset,
    codec_write_buffer_if.slave bus,
    output wbuf_state_t         dbg_state
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    wbuf_state_t        state_q;
    wbuf_state_t        state_d;
    logic [PW-1:0]      wptr_q;
    logic [PW-1:0]      rptr_q;
    logic [LW-1:0]      level_q;
    logic [WIDTH-1:0]   hold_l_q;
    logic [WIDTH-1:0]   hold_r_q;
    logic [15:0]        ucnt_q;
    logic               ovf_q;

    logic               in_ready;
    logic               handshake;
    logic               push;
    logic               drop;
    logic               pop;
    logic               uflow;
    logic [2*WIDTH-1:0] head;

    // Full is decoded from the registered level only, so a same-cycle pop
    // never frees a slot for a push.
    assign in_ready  = (level_q != LW'(DEPTH));
    assign handshake = bus.write_ready && !reset;
    assign push      = bus.in_valid && in_ready;
    assign drop      = bus.in_valid && !in_ready;

    stereo_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .wr_en   (push),
        .wr_addr (wptr_q),
        .wr_data ({bus.in_left, bus.in_right}),
        .rd_addr (rptr_q),
        .rd_data (head)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_PRIMING;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: leave PRIMING once the threshold is met, fall back on underflow.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_PRIMING: begin
                if (level_q >= LW'(PRIME)) begin
                    state_d = ST_STREAMING;
                end
            end
            ST_STREAMING: begin
                if (uflow) begin
                    state_d = ST_PRIMING;
                end
            end
            default: state_d = ST_PRIMING;
        endcase
    end

    // FSM outputs: a STREAMING handshake pops if data exists, else it is an underflow.
    always_comb begin
        pop   = 1'b0;
        uflow = 1'b0;
        if (state_q == ST_STREAMING && handshake) begin
            if (level_q != '0) begin
                pop = 1'b1;
            end else begin
                uflow = 1'b1;
            end
        end
    end

    // Pointers, occupancy, holding register and status counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            level_q  <= '0;
            hold_l_q <= '0;
            hold_r_q <= '0;
            ucnt_q   <= UNDERFLOW_RESET;
            ovf_q    <= 1'b0;
        end else begin
            if (push) begin
                wptr_q <= wptr_q + PW'(1);
            end
            if (pop) begin
                rptr_q   <= rptr_q + PW'(1);
                hold_l_q <= head[2*WIDTH-1:WIDTH];
                hold_r_q <= head[WIDTH-1:0];
            end
            case ({push, pop})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
            if (uflow) begin
                ucnt_q <= sat_inc16(ucnt_q);
            end
            if (drop) begin
                ovf_q <= 1'b1;
            end
        end
    end

    assign bus.in_ready        = in_ready;
    assign bus.write           = handshake;
    assign bus.writedata_left  = hold_l_q;
    assign bus.writedata_right = hold_r_q;
    assign bus.level           = level_q;
    assign bus.underflow_count = ucnt_q;
    assign bus.overflow        = ovf_q;
    assign dbg_state           = state_q;
endmodule

// File: tb/tb_codec_write_buffer.sv
// Self-checking bench for codec_write_buffer.
module tb_codec_write_buffer;
  import codec_write_buffer_pkg::*;

  localparam int W     = SAMPLE_W;
  localparam int DEPTH = 8;
  localparam int PRIME = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  codec_write_buffer_if #(.WIDTH(W), .DEPTH(DEPTH)) bus ();
  codec_write_buffer_if #(.WIDTH(W), .DEPTH(4))     sat_bus ();
  wbuf_state_t dbg_state;
  wbuf_state_t sat_state;

  codec_write_buffer #(.WIDTH(W), .DEPTH(DEPTH), .PRIME(PRIME)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // Second instance preloaded near the counter ceiling.
  codec_write_buffer #(.WIDTH(W), .DEPTH(4), .PRIME(1), .UNDERFLOW_RESET(16'hFFFD)) sat_dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (sat_bus),
    .dbg_state (sat_state)
  );

  // ---------------- scoreboard / model ----------------
  int checks = 0;
  int errors = 0;
  logic [2*W-1:0] exp_q[$];
  logic [2*W-1:0] m_hold;
  logic           m_stream;
  logic [15:0]    m_ucnt;
  logic           m_ovf;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_hold   = '0;
    m_stream = 1'b0;
    m_ucnt   = 16'd0;
    m_ovf    = 1'b0;
  endtask

  function automatic logic [2*W-1:0] mk_pair(input int k);
    logic [W-1:0] l;
    logic [W-1:0] r;
    l = W'(k);
    r = W'(-k);
    return {l, r};
  endfunction

  // ---------------- driver tasks ----------------
  // One main-DUT cycle: drive, check outputs at negedge, advance the model.
  task automatic step(input logic iv, input logic [2*W-1:0] pair, input logic wr);
    int   sz;
    logic push;
    logic pop;
    logic uf;
    bus.in_valid    = iv;
    bus.in_left     = pair[2*W-1:W];
    bus.in_right    = pair[W-1:0];
    bus.write_ready = wr;
    @(negedge clk);
    sz = exp_q.size();
    check_val("level",     64'(bus.level), 64'(sz));
    check_val("in_ready",  64'(bus.in_ready), 64'(sz != DEPTH));
    check_val("write",     64'(bus.write), 64'(wr));
    check_val("wd_left",   64'(bus.writedata_left), 64'(m_hold[2*W-1:W]));
    check_val("wd_right",  64'(bus.writedata_right), 64'(m_hold[W-1:0]));
    check_val("state",     64'(dbg_state), 64'(m_stream));
    check_val("ucnt",      64'(bus.underflow_count), 64'(m_ucnt));
    check_val("overflow",  64'(bus.overflow), 64'(m_ovf));
    push = iv && (sz != DEPTH);
    pop  = wr && m_stream && (sz > 0);
    uf   = wr && m_stream && (sz == 0);
    if (pop) m_hold = exp_q.pop_front();
    if (push) exp_q.push_back(pair);
    if (iv && !push) m_ovf = 1'b1;
    if (uf && m_ucnt != 16'hFFFF) m_ucnt = m_ucnt + 16'd1;
    if (!m_stream) m_stream = (sz >= PRIME);
    else if (uf) m_stream = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // One reset cycle with traffic on the inputs; write must stay low.
  task automatic do_reset();
    reset           = 1'b1;
    bus.in_valid    = 1'b1;
    bus.in_left     = W'(77);
    bus.in_right    = W'(-77);
    bus.write_ready = 1'b1;
    @(negedge clk);
    check_val("write_in_reset", 64'(bus.write), 64'(0));
    @(posedge clk);
    #1;
    reset           = 1'b0;
    bus.in_valid    = 1'b0;
    bus.write_ready = 1'b0;
    model_reset();
  endtask

  task automatic sat_cycle(input logic iv, input logic wr);
    sat_bus.in_valid    = iv;
    sat_bus.in_left     = W'(5);
    sat_bus.in_right    = W'(-5);
    sat_bus.write_ready = wr;
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int pushed;
    bus.in_valid = 1'b0;
    bus.in_left = '0;
    bus.in_right = '0;
    bus.write_ready = 1'b0;
    sat_bus.in_valid = 1'b0;
    sat_bus.in_left = '0;
    sat_bus.in_right = '0;
    sat_bus.write_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Reset state, then priming with a handshake every third cycle, ending in underflow.
    step(1'b0, '0, 1'b0);
    pushed = 0;
    for (int c = 0; c < 30; c++) begin
      logic iv;
      iv = (pushed < 4);
      step(iv, mk_pair(pushed + 1), (c % 3) == 2);
      if (iv) pushed++;
    end
    check_val("uflow_once", 64'(bus.underflow_count), 64'(1));
    check_val("uflow_hold_l", 64'(bus.writedata_left), 64'(W'(4)));

    // Overflow: nine pushes, no handshakes, then drain in order.
    do_reset();
    for (int k = 1; k <= 9; k++) step(1'b1, mk_pair(k), 1'b0);
    check_val("ovf_level", 64'(bus.level), 64'(DEPTH));
    check_val("ovf_flag", 64'(bus.overflow), 64'(1));
    for (int k = 0; k < 12; k++) step(1'b0, '0, 1'b1);

    // Concurrent push and pop at level 3, wrapping the pointers.
    do_reset();
    for (int k = 1; k <= 4; k++) step(1'b1, mk_pair(k), 1'b0);
    step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b1);
    for (int k = 5; k <= 24; k++) step(1'b1, mk_pair(k), 1'b1);
    check_val("conc_level", 64'(bus.level), 64'(3));
    for (int k = 0; k < 6; k++) step(1'b0, '0, 1'b1);

    // Random traffic.
    do_reset();
    for (int k = 0; k < 120; k++) begin
      logic [2*W-1:0] rp;
      rp = {W'($urandom), W'($urandom)};
      step(1'($urandom_range(0, 1)), rp, $urandom_range(0, 2) == 0);
    end

    // Reset mid-stream at level 5.
    do_reset();
    for (int k = 1; k <= 5; k++) step(1'b1, mk_pair(k + 100), 1'b0);
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1);
    do_reset();
    step(1'b0, '0, 1'b1);

    // Saturation of the underflow counter.
    check_val("sat_init", 64'(sat_bus.underflow_count), 64'(16'hFFFD));
    for (int r = 1; r <= 4; r++) begin
      int e;
      sat_cycle(1'b1, 1'b0);
      sat_cycle(1'b0, 1'b0);
      sat_cycle(1'b0, 1'b1);
      sat_cycle(1'b0, 1'b1);
      e = (32'hFFFD + r > 32'hFFFF) ? 32'hFFFF : 32'hFFFD + r;
      check_val("sat_ucnt", 64'(sat_bus.underflow_count), 64'(e));
      check_val("sat_state", 64'(sat_state), 64'(ST_PRIMING));
    end

    // ---------------- report ----------------
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/codec_write_buffer.md
# codec_write_buffer

Stereo sample buffer between the FIR filter outputs and the audio CODEC write port. Accepts filtered left/right sample pairs, queues them in a small FIFO, primes to a fill threshold, then supplies one pair per CODEC `write_ready` handshake. Underflow holds the last sample and is counted; overflow drops the incoming pair and is flagged. This decouples filter timing from the CODEC DAC frame rate.

## Interface

Parameters:
- `WIDTH`, 24, sample width per channel (signed two's complement).
- `DEPTH`, 8, FIFO depth in stereo pairs. Power of 2, ≥ 4.
- `PRIME`, 4, fill level that must be reached before streaming starts. 1 ≤ PRIME ≤ DEPTH.

Ports (clock is `clk`, reset is `reset`; one clock; reset is synchronous and active-high):
- `clk` in 1: system clock (CLOCK_50 domain).
- `reset` in 1: synchronous, active-high.
- `in_valid` in 1: sample pair present on `in_left`/`in_right`.
- `in_left` in WIDTH: left sample from the filter.
- `in_right` in WIDTH: right sample from the filter.
- `in_ready` out 1: FIFO not full.
- `write_ready` in 1: CODEC can accept a pair this cycle.
- `write` out 1: write strobe to the CODEC.
- `writedata_left` out WIDTH: left sample to the CODEC.
- `writedata_right` out WIDTH: right sample to the CODEC.
- `level` out $clog2(DEPTH)+1: current FIFO occupancy.
- `underflow_count` out 16: saturating count of underflow events.
- `overflow` out 1: sticky; set when a pair is dropped.

## Operation

- Storage: DEPTH×(2·WIDTH) array with read and write pointers of $clog2(DEPTH) bits that wrap modulo DEPTH. `level` is held as an explicit counter.
- Push: `in_valid && in_ready` writes the pair at wptr, wptr+1, level+1.
- Drop: `in_valid && !in_ready` stores nothing and sets `overflow`. No bypass; a full FIFO refuses pushes even when a pop occurs in the same cycle.
- Holding register `hold_l`/`hold_r` drives `writedata_*` directly (registered outputs).
- Handshake: `write = write_ready && !reset` (combinational). A handshake is any cycle with `write` high.
- FSM states:
  - PRIMING (reset state): handshakes are served from `hold` unchanged, with no pop. Moves to STREAMING on any cycle with `level >= PRIME`.
  - STREAMING:
    - Handshake with level > 0: pop the head into `hold`, rptr+1, level−1.
    - Handshake with level == 0: underflow. `hold` is kept, `underflow_count` increments (saturating at 16'hFFFF), and state returns to PRIMING.
- Simultaneous push and pop: both occur and `level` is unchanged. A push into an empty FIFO is not visible to a pop in the same cycle.
- Reset values: state PRIMING, pointers 0, `level` 0, `hold` 0, `underflow_count` 0, `overflow` 0, `in_ready` 1, `write` 0.

## Timing

- Pushed pair to FIFO head: 1 cycle.
- Pop updates `hold` on the clock edge ending the handshake cycle. The new value is presented at the next handshake, so the output runs one pair behind the FIFO head (one-sample pipeline).
- The PRIMING→STREAMING transition registers at the edge after `level` reaches PRIME. The first pop occurs at the first handshake after that.
- `in_ready` is `level != DEPTH`, decoded from registered state.
- Reset mid-stream: all contents are discarded next cycle. `write` is forced low while `reset` is high.

## Structure

- Shared package: `SAMPLE_W` = 24 and the stereo-pair typedef `{left, right}`, common with the filter and the top level.
- One sub-module, `stereo_fifo_mem`: the DEPTH×2·WIDTH array with synchronous write and asynchronous read of the head. The FSM, counters and holding register stay in `codec_write_buffer`.

## Test plan

- Priming: reset, push pairs (1,−1),(2,−2),(3,−3),(4,−4) with `write_ready` pulsed every 3 cycles → `write` outputs are 0/0 until level=4, then the next handshakes present 1/−1 and 2/−2 in order (one-handshake lag). `level` tracks pushes minus pops.
- Overflow: DEPTH=8, 9 pushes, no handshakes → `in_ready`=0 after the 8th push, ninth pair dropped, `overflow`=1, `level`=8, FIFO order 1..8 preserved.
- Underflow: stream 4 pairs, then 6 handshakes with no pushes → `hold` stays at the last pair, `underflow_count`=1, state PRIMING. Further handshakes do not increment the count again.
- Concurrent: level=3 in STREAMING, push and handshake in the same cycle → level stays 3, pointer wrap past DEPTH−1 is correct, data order intact over 20 pairs.
- Reset mid-stream: level=5, assert `reset` for 1 cycle → `level`=0, `hold`=0, `write`=0 during reset, `underflow_count`=0, state PRIMING.
- Saturation: force 65 536 underflow events (or preload the counter) → `underflow_count` holds at 16'hFFFF.
